// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one response out.
// A cycle budget from command acceptance aborts transactions to absent or hung slaves.
module axil_cmd_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 5,
    parameter int C_TIMEOUT          = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int CW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((C_TIMEOUT > 0) ? C_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP
    } state_t;

    state_t r_state, w_state_nxt;

    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] r_wstrb;
    logic                            r_awvalid, r_wvalid;
    logic [CW-1:0]                   r_cnt, w_cnt_nxt;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]                      r_resp;
    logic                            r_tmo;
    logic                            w_accept, w_busy, w_done, w_tmo_hit;

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_accept    = (r_state == S_IDLE) && cmd_valid;
        w_busy      = (r_state == S_WR_ADDR) || (r_state == S_WR_RESP) ||
                      (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);
        w_cnt_nxt   = r_cnt + 1'b1;
        // The acceptance cycle counts toward the budget, hence the compare on the
        // post-increment value; >= keeps a late phase that already won a race bounded.
        w_tmo_hit   = (C_TIMEOUT > 0) && w_busy && (w_cnt_nxt >= TMO_LAST);
        case (r_state)
            S_IDLE:    if (cmd_valid) w_state_nxt = cmd_write ? S_WR_ADDR : S_RD_ADDR;
            S_WR_ADDR: w_done = (!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY);
            S_WR_RESP: w_done = M_AXI_BVALID;
            S_RD_ADDR: w_done = M_AXI_ARREADY;
            S_RD_DATA: w_done = M_AXI_RVALID;
            S_RSP:     if (rsp_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_done) begin
            case (r_state)
                S_WR_ADDR: w_state_nxt = S_WR_RESP;
                S_RD_ADDR: w_state_nxt = S_RD_DATA;
                default:   w_state_nxt = S_RSP;
            endcase
        end else if (w_tmo_hit) begin
            w_state_nxt = S_RSP;
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) r_state <= S_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
            r_tmo     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_awvalid <= cmd_write;
                r_wvalid  <= cmd_write;
                r_cnt     <= '0;
            end else if (w_busy) begin
                r_cnt <= w_cnt_nxt;
            end
            // AW and W retire independently; an abort drops whichever is still pending.
            if (r_state == S_WR_ADDR) begin
                if (M_AXI_AWREADY || w_tmo_hit) r_awvalid <= 1'b0;
                if (M_AXI_WREADY  || w_tmo_hit) r_wvalid  <= 1'b0;
            end
            if (w_done && r_state == S_WR_RESP) begin
                r_rdata <= '0;
                r_resp  <= M_AXI_BRESP;
                r_tmo   <= 1'b0;
            end else if (w_done && r_state == S_RD_DATA) begin
                r_rdata <= M_AXI_RDATA;
                r_resp  <= M_AXI_RRESP;
                r_tmo   <= 1'b0;
            end else if (!w_done && w_tmo_hit) begin
                r_rdata <= '0;
                r_resp  <= 2'b11;
                r_tmo   <= 1'b1;
            end
        end
    end

    assign cmd_ready     = (r_state == S_IDLE);
    assign rsp_valid     = (r_state == S_RSP);
    assign rsp_rdata     = r_rdata;
    assign rsp_resp      = r_resp;
    assign rsp_timeout   = r_tmo;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = (r_state == S_WR_RESP);
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (r_state == S_RD_ADDR);
    assign M_AXI_RREADY  = (r_state == S_RD_DATA);

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: behavioural AXI4-Lite slave with a small register array,
// scoreboard of expected responses, a vector table and hand-timed corner sequences.
module tb_axil_cmd_master;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [4:0]  AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    axil_cmd_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(5), .C_TIMEOUT(TMO)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } exp_t;

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        int          awd, wd, bd, ard, rd;
        logic [1:0]  sresp;
        logic [31:0] er;
        logic [1:0]  eresp;
        logic        etmo;
    } vec_t;

    exp_t sbq[$];
    exp_t m_e;
    int   checks = 0, errors = 0, rsp_cnt = 0, b_cnt = 0, n_push = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: a handshake seen at the negedge completes at the next posedge.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            chk("sb_pending", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                m_e = sbq.pop_front();
                chk("sb_rdata", rsp_rdata, m_e.rdata);
                chk("sb_resp", rsp_resp, m_e.resp);
                chk("sb_timeout", rsp_timeout, m_e.tmo);
            end
        end
    end

    // Slave model knobs and state; all decisions are made at the negedge.
    int          aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
    logic        ar_never = 0, rd_ovr_en = 0;
    logic [31:0] rd_ovr = 0;
    logic [1:0]  bresp_k = 0, rresp_k = 0;
    logic [31:0] mem [8];
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic        aw_got, w_got, ar_got, b_fire, r_fire;
    logic [4:0]  s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;

    always @(negedge clk) begin
        if (rst) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
            ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        end else begin
            if (b_fire) begin
                BVALID = 0; b_fire = 0; aw_got = 0; w_got = 0; b_wait = 0;
            end else if (BVALID) begin
                if (BREADY) begin b_fire = 1; b_cnt++; end
            end else if (aw_got && w_got) begin
                if (b_wait >= b_d) begin
                    BVALID = 1; BRESP = bresp_k;
                    for (int i = 0; i < 4; i++)
                        if (s_wstrb[i]) mem[s_awaddr[4:2]][8*i +: 8] = s_wdata[8*i +: 8];
                    if (BREADY) begin b_fire = 1; b_cnt++; end
                end else b_wait++;
            end
            if (AWVALID && !aw_got) begin
                aw_wait++; AWREADY = (aw_wait > aw_d);
                if (AWREADY) begin aw_got = 1; s_awaddr = AWADDR; end
            end else begin AWREADY = 0; aw_wait = 0; end
            if (WVALID && !w_got) begin
                w_wait++; WREADY = (w_wait > w_d);
                if (WREADY) begin w_got = 1; s_wdata = WDATA; s_wstrb = WSTRB; end
            end else begin WREADY = 0; w_wait = 0; end

            if (r_fire) begin
                RVALID = 0; r_fire = 0; ar_got = 0; r_wait = 0;
            end else if (RVALID) begin
                if (RREADY) r_fire = 1;
            end else if (ar_got) begin
                if (r_wait >= r_d) begin
                    RVALID = 1; RRESP = rresp_k;
                    RDATA = rd_ovr_en ? rd_ovr : mem[s_araddr[4:2]];
                    if (RREADY) r_fire = 1;
                end else r_wait++;
            end
            if (ARVALID && !ar_got && !ar_never) begin
                ar_wait++; ARREADY = (ar_wait > ar_d);
                if (ARREADY) begin ar_got = 1; s_araddr = ARADDR; end
            end else begin ARREADY = 0; ar_wait = 0; end
        end
    end

    task automatic drive_cmd(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    endtask

    task automatic push_exp(input logic [31:0] er, input logic [1:0] eresp, input logic etmo);
        exp_t e;
        e.rdata = er; e.resp = eresp; e.tmo = etmo;
        sbq.push_back(e);
        n_push++;
    endtask

    // Presents a command and pushes its expected response once acceptance is certain.
    task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] er, input logic [1:0] eresp, input logic etmo);
        bit ok = 0;
        @(posedge clk); #1;
        drive_cmd(w, a, d, s);
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; push_exp(er, eresp, etmo); end
            @(posedge clk); #1;
        end
        cmd_valid = 0;
        chk("cmd_accept", ok, 1);
    endtask

    task automatic wait_rsp();
        bit ok = 0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (sbq.size() == 0) ok = 1;
        end
        chk("rsp_wait", ok, 1);
    endtask

    vec_t vt [12];
    int   b0, r0, early;
    bit   seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 1;
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        //           w     addr   wdata         strb  awd wd bd ard rd sresp  exp_rdata     resp   tmo
        vt[0]  = '{1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0,  0, 2'b00, 32'h00000000, 2'b00, 1'b0};
        vt[1]  = '{1'b0, 5'h04, 32'h0,        4'h0, 0, 0, 0, 0,  0, 2'b00, 32'hDEADBEEF, 2'b00, 1'b0};
        vt[2]  = '{1'b1, 5'h08, 32'h11223344, 4'h5, 1, 2, 0, 0,  0, 2'b00, 32'h00000000, 2'b00, 1'b0};
        vt[3]  = '{1'b0, 5'h08, 32'h0,        4'h0, 0, 0, 0, 0,  0, 2'b00, 32'h00220044, 2'b00, 1'b0};
        vt[4]  = '{1'b1, 5'h1C, 32'hCAFEF00D, 4'hF, 2, 0, 1, 0,  0, 2'b00, 32'h00000000, 2'b00, 1'b0};
        vt[5]  = '{1'b0, 5'h1C, 32'h0,        4'h0, 0, 0, 0, 1,  2, 2'b00, 32'hCAFEF00D, 2'b00, 1'b0};
        vt[6]  = '{1'b0, 5'h04, 32'h0,        4'h0, 0, 0, 0, 0,  0, 2'b10, 32'hDEADBEEF, 2'b10, 1'b0};
        vt[7]  = '{1'b1, 5'h0C, 32'h0,        4'hF, 0, 0, 0, 0,  0, 2'b10, 32'h00000000, 2'b10, 1'b0};
        vt[8]  = '{1'b0, 5'h04, 32'h0,        4'h0, 0, 0, 0, 14, 0, 2'b00, 32'hDEADBEEF, 2'b00, 1'b0};
        vt[9]  = '{1'b0, 5'h04, 32'h0,        4'h0, 0, 0, 0, 15, 0, 2'b00, 32'h00000000, 2'b11, 1'b1};
        vt[10] = '{1'b1, 5'h10, 32'h55AA55AA, 4'hF, 5, 9, 0, 0,  0, 2'b00, 32'h00000000, 2'b00, 1'b0};
        vt[11] = '{1'b0, 5'h10, 32'h0,        4'h0, 0, 0, 0, 0,  5, 2'b00, 32'h55AA55AA, 2'b00, 1'b0};

        repeat (3) @(posedge clk); #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_valids", {AWVALID, WVALID, ARVALID}, 0);
        chk("rst_readies", {BREADY, RREADY}, 0);
        chk("rst_rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
        chk("rst_prot", {AWPROT, ARPROT}, 0);
        rst = 0;

        for (int i = 0; i < 12; i++) begin
            aw_d = vt[i].awd; w_d = vt[i].wd; b_d = vt[i].bd; ar_d = vt[i].ard; r_d = vt[i].rd;
            bresp_k = vt[i].w ? vt[i].sresp : 2'b00;
            rresp_k = vt[i].w ? 2'b00 : vt[i].sresp;
            issue(vt[i].w, vt[i].a, vt[i].d, vt[i].s, vt[i].er, vt[i].eresp, vt[i].etmo);
            wait_rsp();
        end
        aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0; bresp_k = 0; rresp_k = 0;

        // Zero-wait write followed back-to-back by a read of the same register.
        @(posedge clk); #1;
        drive_cmd(1, 5'h18, 32'h0BADCAFE, 4'hF); push_exp(32'h0, 2'b00, 1'b0);
        @(posedge clk); #1; cmd_valid = 0;
        chk("lat_w1_awvalid", AWVALID, 1);
        chk("lat_w1_wvalid", WVALID, 1);
        chk("lat_w1_cmd_ready", cmd_ready, 0);
        chk("lat_w1_awaddr", AWADDR, 5'h18);
        @(posedge clk); #1;
        chk("lat_w2_valids", {AWVALID, WVALID}, 0);
        chk("lat_w2_bready", BREADY, 1);
        @(posedge clk); #1;
        chk("lat_w3_rsp_valid", rsp_valid, 1);
        @(posedge clk); #1;
        chk("lat_w4_cmd_ready", cmd_ready, 1);
        drive_cmd(0, 5'h18, 32'h0, 4'h0); push_exp(32'h0BADCAFE, 2'b00, 1'b0);
        @(posedge clk); #1; cmd_valid = 0;
        chk("lat_r1_arvalid", ARVALID, 1);
        @(posedge clk); #1;
        chk("lat_r2_rready", RREADY, 1);
        chk("lat_r2_arvalid", ARVALID, 0);
        @(posedge clk); #1;
        chk("lat_r3_rsp_valid", rsp_valid, 1);
        wait_rsp();

        // Skewed write: W accepted three cycles before AW.
        aw_d = 3; w_d = 0; b0 = b_cnt; r0 = rsp_cnt;
        @(posedge clk); #1;
        drive_cmd(1, 5'h14, 32'hA1B2C3D4, 4'hF); push_exp(32'h0, 2'b00, 1'b0);
        @(posedge clk); #1; cmd_valid = 0;
        chk("skew_c1_both", {AWVALID, WVALID}, 2'b11);
        @(posedge clk); #1;
        chk("skew_c2_w_dropped", {AWVALID, WVALID}, 2'b10);
        @(posedge clk); #1;
        chk("skew_c3_aw_held", {AWVALID, WVALID, BREADY}, 3'b100);
        @(posedge clk); #1;
        chk("skew_c4_aw_held", {AWVALID, WVALID, BREADY}, 3'b100);
        @(posedge clk); #1;
        chk("skew_c5_bready", {AWVALID, WVALID, BREADY}, 3'b001);
        wait_rsp();
        chk("skew_one_b", b_cnt - b0, 1);
        chk("skew_one_rsp", rsp_cnt - r0, 1);
        aw_d = 0;

        // Timeout: slave never accepts AR; response appears 16 cycles after acceptance.
        ar_never = 1; early = 0;
        @(posedge clk); #1;
        drive_cmd(0, 5'h18, 32'h0, 4'h0); push_exp(32'h0, 2'b11, 1'b1);
        @(posedge clk); #1; cmd_valid = 0;
        for (int k = 1; k <= 15; k++) begin
            if (rsp_valid) early++;
            if (k == 15) chk("tmo_c15_arvalid", ARVALID, 1);
            @(posedge clk); #1;
        end
        chk("tmo_no_early_rsp", early, 0);
        chk("tmo_c16_rsp_valid", rsp_valid, 1);
        chk("tmo_c16_timeout", rsp_timeout, 1);
        chk("tmo_c16_resp", rsp_resp, 2'b11);
        chk("tmo_c16_rdata", rsp_rdata, 0);
        chk("tmo_c16_arvalid", ARVALID, 0);
        wait_rsp();
        @(posedge clk); #1;
        chk("tmo_after_arvalid", ARVALID, 0);
        ar_never = 0;

        // Response backpressure with a pending second command.
        rd_ovr_en = 1; rd_ovr = 32'h12345678; rsp_ready = 0;
        issue(0, 5'h08, 32'h0, 4'h0, 32'h12345678, 2'b00, 1'b0);
        seen = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            if (rsp_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk("bp_rsp_seen", seen, 1);
        rd_ovr_en = 0;
        drive_cmd(1, 5'h0C, 32'h0F0F0F0F, 4'hF);
        for (int k = 0; k < 10; k++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout}, {32'h12345678, 2'b00, 1'b0});
            chk("bp_cmd_ready", cmd_ready, 0);
            @(posedge clk); #1;
        end
        push_exp(32'h0, 2'b00, 1'b0);
        rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp_idle_cmd_ready", cmd_ready, 1);
        chk("bp_idle_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1; cmd_valid = 0;
        chk("bp_second_accepted", {cmd_ready, AWVALID}, 2'b01);
        wait_rsp();

        // Asynchronous reset while waiting in the read data phase.
        r_d = 8; r0 = rsp_cnt;
        @(posedge clk); #1;
        drive_cmd(0, 5'h04, 32'h0, 4'h0);
        @(posedge clk); #1; cmd_valid = 0;
        @(posedge clk); #1;
        chk("rst_mid_rready", RREADY, 1);
        #2 rst = 1; #1;
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        chk("rst_mid_valids", {AWVALID, WVALID, ARVALID, rsp_valid}, 0);
        chk("rst_mid_readies", {BREADY, RREADY}, 0);
        chk("rst_mid_rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
        repeat (2) @(posedge clk); #1;
        rst = 0; r_d = 0;
        issue(1, 5'h00, 32'h13579BDF, 4'hF, 32'h0, 2'b00, 1'b0);
        wait_rsp();
        chk("rst_mid_no_rsp", rsp_cnt - r0, 1);
        issue(0, 5'h00, 32'h0, 4'h0, 32'h13579BDF, 2'b00, 1'b0);
        wait_rsp();

        repeat (3) @(posedge clk); #1;
        chk("sb_drained", sbq.size(), 0);
        chk("rsp_total", rsp_cnt, n_push);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream (write or read, address, data, strobes) into AXI4-Lite transactions. It sits directly upstream of the AXI register file and drives its S_AXI port, either directly or through an interconnect. Typical command sources are a debug UART/JTAG bridge or a bring-up sequencer. Each command returns exactly one response, carrying read data, the AXI response code and a timeout flag. The timeout releases the command source when the slave is absent or hung.

## Interface
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 5, byte address width; matches the register file's address width.
- C_TIMEOUT, 1024, cycles allowed from command acceptance to AXI completion; 0 disables the timeout.
- M_AXI_ACLK  in  1  clock; the only clock.
- M_AXI_ARESET  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data; ignored for reads.
- cmd_wstrb  in  4  write strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  32  read data; 0 for writes and for timeouts.
- rsp_resp  out  2  BRESP/RRESP; 2'b11 on timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master signals at the widths above. AWPROT and ARPROT are tied to 3'b000.

## Operation
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE
  - cmd_ready = 1.
  - On cmd_valid, latch addr, wdata, wstrb and write into holding registers.
  - Clear the timeout counter.
  - Go to WR_ADDR if write, else RD_ADDR.
- WR_ADDR
  - AWVALID and WVALID assert together, from registered outputs.
  - Each valid drops the cycle after its own handshake; aw_done and w_done are tracked independently.
  - Move to WR_RESP once both handshakes have completed, including when both complete in the same cycle.
- WR_RESP
  - BREADY = 1.
  - On BVALID, capture BRESP, set rsp_rdata = 0, go to RSP.
- RD_ADDR
  - ARVALID = 1 until ARREADY, then go to RD_DATA.
- RD_DATA
  - RREADY = 1.
  - On RVALID, capture RDATA and RRESP, go to RSP.
- RSP
  - rsp_valid = 1; rsp_* outputs stay stable until rsp_ready, then go to IDLE.
  - cmd_ready = 0 in every state except IDLE.
- Timeout (C_TIMEOUT > 0)
  - The counter increments each cycle in WR_ADDR, WR_RESP, RD_ADDR and RD_DATA.
  - When the count reaches C_TIMEOUT-1 with no completing handshake in that cycle:
    - drop all AXI valids and readies;
    - set rsp_timeout = 1, rsp_resp = 2'b11, rsp_rdata = 0;
    - go to RSP.
  - This abort deliberately violates AXI and exists for absent or hung slaves only.
  - If a completing handshake and the timeout coincide, the handshake wins and rsp_timeout = 0.
- Only one transaction is outstanding; there is no pipelining.

## Timing
- Reset values: every AXI valid and ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_resp = 0; rsp_timeout = 0; state = IDLE; cmd_ready = 1.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values; no response is produced.
- Zero-wait slave, write (command accepted at cycle 0):
  - AW and W valid at cycle 1, handshakes at cycle 1;
  - BREADY at cycle 2; B handshake at cycle 2 or later;
  - rsp_valid the cycle after the B handshake, i.e. cycle 3 minimum.
- Zero-wait slave, read: ARVALID at cycle 1, RREADY at cycle 2, rsp_valid at cycle 3 minimum.
- Back-to-back commands: the next command is accepted in the IDLE cycle following the rsp handshake, giving a 4-cycle minimum per command.
- AWADDR, WDATA, WSTRB and ARADDR are driven from the holding registers and stay stable while the corresponding valid is high.

## Test plan
- Write then read back against the register file:
  - write addr 0x04, data 0xDEADBEEF, wstrb 0xF → BRESP = 2'b00, rsp_rdata = 0;
  - read addr 0x04 → rsp_rdata equals that register's read input (loop reg1_out back to reg1_in, giving 0xDEADBEEF), rsp_resp = 2'b00.
- Skewed write handshakes: slave asserts WREADY 3 cycles before AWREADY → WVALID drops right after the W handshake, AWVALID stays high, exactly one B is awaited, a single response is produced.
- Timeout: C_TIMEOUT = 16, slave never asserts ARREADY → rsp_valid 16 cycles after acceptance, rsp_timeout = 1, rsp_resp = 2'b11, ARVALID low from then on.
- Response backpressure: rsp_ready held low for 10 cycles with RDATA = 0x12345678 → rsp outputs stable throughout, cmd_ready = 0, a new cmd_valid is not accepted until after the rsp handshake.
- Reset mid-read: assert M_AXI_ARESET while in RD_DATA → all outputs at reset values asynchronously; after release, a write to 0x00 completes normally.
- Error pass-through: slave returns RRESP = 2'b10 → rsp_resp = 2'b10, rsp_timeout = 0.
